// File: rtl/handshake_rr_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | handshake_arb_pkg : shared types and helpers for handshake_rr_arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package handshake_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_rr_arbiter_if.sv
// +----------------------------------------------------------------------+
// | handshake_rr_arbiter_if : NREQ source channels plus one drain channel |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface handshake_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  // slave: the arbiter; master: the surrounding sources and drain
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_id
  );
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_id
  );
endinterface

`default_nettype wire

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational rotating-priority picker starting at ptr     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  int w_j;

  // Scan from the farthest position back so the entry nearest ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (req[w_j]) begin
        found = 1'b1;
        idx   = IDW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/handshake_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | handshake_rr_arbiter : packet-atomic round-robin mux of NREQ sources |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  handshake_rr_arbiter_if.slave  bus,
  output logic                   busy,
  output logic [CNTW-1:0]        pkt_count
);

  arb_state_t       r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_own, w_own_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [IDW-1:0]   r_out_id;

  logic             w_pick_found;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_grant_valid;
  logic [IDW-1:0]   w_grant;
  logic             w_can_load;
  logic             w_accept;
  logic             w_beat_last;
  logic [WIDTH-1:0] w_beat_data;
  logic [NREQ-1:0]  w_req_ready;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  // Only the granted lane's inputs are sampled, so X elsewhere cannot leak.
  always_comb begin
    w_can_load    = !r_out_valid || bus.out_ready;
    w_grant_valid = w_pick_found;
    w_grant       = w_pick_idx;
    if (r_state == ARB_LOCKED) begin
      w_grant_valid = 1'b1;
      w_grant       = r_own;
    end
    w_beat_last = bus.req_last[w_grant];
    w_beat_data = bus.req_data[int'(w_grant)*WIDTH +: WIDTH];
    w_accept    = w_can_load && w_grant_valid && bus.req_valid[w_grant] && !rst;
    w_req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req_ready[i] = w_can_load && w_grant_valid && (w_grant == IDW'(i)) && !rst;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_own_nxt   = r_own;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      if (w_beat_last) begin
        w_state_nxt = ARB_IDLE;
        w_ptr_nxt   = IDW'(next_idx(int'(w_grant), NREQ));
        w_cnt_nxt   = r_cnt + CNTW'(1);
      end else begin
        w_state_nxt = ARB_LOCKED;
        w_own_nxt   = w_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat_data;
      r_out_last  <= w_beat_last;
      r_out_id    <= w_grant;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;
  assign busy          = (r_state == ARB_LOCKED);
  assign pkt_count     = r_cnt;

endmodule

`default_nettype wire

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Shares one downstream handshake channel (drain side) between NREQ upstream source channels.
- Round-robin, packet-atomic arbitration with valid/ready flow control.
- A single registered output stage gives full throughput under backpressure.
- Sits between the source instances and the drain inside test-level integration; data width matches the handshake interface default.

Parameters:
- WIDTH, 32, payload width per beat (same as handshake WIDTH).
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), width of the requester index (derived; do not override).
- CNTW, 16, width of the packet statistics counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_data  input  NREQ*WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  input  NREQ  per-requester end-of-packet flag.
- req_ready  output  NREQ  per-requester accept.
- out_valid  output  1  downstream beat valid (registered).
- out_data  output  WIDTH  downstream payload (registered).
- out_last  output  1  downstream end-of-packet (registered).
- out_id  output  IDW  index of the requester that owns the current beat (registered).
- out_ready  input  1  downstream accept.
- busy  output  1  high while in LOCKED state.
- pkt_count  output  CNTW  count of completed packets accepted from upstream.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - out_valid=0, out_data=0, out_last=0, out_id=0, pkt_count=0.
  - state=IDLE, ptr=0.
  - req_ready forced to all 0.
- Output register:
  - can_load = !out_valid || out_ready.
  - req_ready[i] = can_load && (grant == i) && (rst == 0). At most one req_ready bit is high per cycle.
  - Accepted beat (req_valid[g] && req_ready[g]) loads out_data/out_last/out_id and sets out_valid=1 on the next edge. Latency is 1 cycle.
  - Downstream transfer (out_valid && out_ready) with no new accept clears out_valid. out_data holds its last value.
  - Simultaneous drain and accept in the same cycle sustains 1 beat/cycle.
  - While out_valid && !out_ready, all output registers hold and all req_ready=0.
- State machine, IDLE / LOCKED, with owner register own (IDW):
  - IDLE: grant = first i with req_valid[i], scanning ptr, ptr+1, ..., wrapping NREQ-1 -> 0. No valid requester means no grant.
  - IDLE, accept with last=0: go to LOCKED, own=grant.
  - IDLE, accept with last=1 (single-beat packet): stay IDLE, ptr=(grant+1) mod NREQ, pkt_count+1.
  - LOCKED: grant = own unconditionally. Other requesters are never readied, even if own drops req_valid mid-packet; the channel stalls.
  - LOCKED, accept with last=1: go to IDLE, ptr=(own+1) mod NREQ, pkt_count+1.
  - An accept with no beat (req_valid low) changes no state.
- busy = (state == LOCKED).
- pkt_count wraps modulo 2^CNTW; it does not saturate.
- ptr wrap: grant NREQ-1 completes -> ptr=0.
- Reset mid-packet: lock dropped, any pending output beat discarded, and the partial packet is lost. Upstream is reset by the same rst.
- req_data, req_last and req_valid of non-granted requesters are ignored. X on those inputs must not propagate.

Decomposition:
- Package handshake_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
  - Function next_idx(idx, n), returning (idx+1) mod n.
- Sub-module rr_pick:
  - Purely combinational rotating priority picker.
  - Inputs: req vector, ptr. Outputs: found, idx.
  - Instantiated once in IDLE grant logic.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, pkt_count=0. After release, the first grant is requester 0.
- Round-robin, single beats: all 4 requesters continuously valid, last=1, out_ready=1, data=i -> out_id sequence 0,1,2,3,0,1; out_valid high every cycle; pkt_count=6 after 6 beats.
- Packet lock: req1 sends a 3-beat packet (A1,A2,A3, last on A3) while req2 is valid -> out shows A1,A2,A3 with out_id=1 contiguous, busy=1 during A1..A2. Next grant goes to req2.
- Backpressure: out_ready=0 for 4 cycles with a beat in the output register -> out_data stable, all req_ready=0. When out_ready=1 returns, throughput resumes at 1 beat/cycle with no beat lost or duplicated.
- Owner stall: req3 locked, deasserts valid for 5 cycles mid-packet while req0 is valid -> req_ready[0] stays 0 and busy stays 1. req3 resumes and completes with last=1, then req0 is granted with ptr=0.
- Reset mid-packet: assert rst while LOCKED with out_valid=1 -> out_valid=0 asynchronously, state IDLE, ptr=0. The first grant after release goes to the lowest valid index.
